// File: rtl/stream_serializer.sv
// Stream serializer: takes a multi-lane packet with a per-lane valid mask and
// emits its set lanes one at a time, lowest lane first, over a valid/ready
// handshake. The next packet may load in the same cycle the last lane leaves.
module stream_serializer #(
    parameter type T     = logic [31:0],
    parameter int  LANES = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [LANES-1:0]           in_mask,
    input  T     [LANES-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output T                           out_data,
    output logic [$clog2(LANES)-1:0]   out_lane,
    output logic                       out_last,
    input  logic                       out_ready
);

    localparam int LANE_W = $clog2(LANES);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [LANES-1:0]   remaining_q;
    logic [LANES-1:0]   remaining_d;
    T     [LANES-1:0]   data_q;
    T     [LANES-1:0]   data_d;
    logic               accept;
    logic               transfer;

    // Packet registers; the state always mirrors whether any lanes remain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            data_q      <= data_d;
        end
    end

    // Lane selection, handshakes and next packet state; flush beats everything.
    always_comb begin
        out_valid   = (state_q == SEND);
        out_lane    = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (remaining_q[i]) begin
                out_lane = LANE_W'(i);
            end
        end
        out_data    = data_q[out_lane];
        out_last    = (remaining_q != '0) &&
                      ((remaining_q & (remaining_q - LANES'(1))) == '0);

        in_ready    = !flush && ((state_q == IDLE) ||
                                 ((state_q == SEND) && out_ready && out_last));
        accept      = in_valid && in_ready;
        transfer    = out_valid && out_ready;

        remaining_d = remaining_q;
        data_d      = data_q;
        if (flush) begin
            remaining_d = '0;
        end else if (accept) begin
            remaining_d = in_mask;
            data_d      = in_data;
        end else if (transfer) begin
            remaining_d = remaining_q & ~(LANES'(1) << out_lane);
        end

        state_d     = (remaining_d != '0) ? SEND : IDLE;
    end

endmodule

// File: tb/tb_stream_serializer.sv
// Testbench for stream_serializer: directed packets feed a scoreboard of
// expected beats, and a monitor pops and compares every transferred lane.
module tb_stream_serializer;

    typedef struct packed {
        logic [1:0]  lane;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic              clk;
    logic              reset_n;
    logic              flush;
    logic              in_valid;
    logic [3:0]        in_mask;
    logic [3:0][31:0]  in_data;
    logic              in_ready;
    logic              out_valid;
    logic [31:0]       out_data;
    logic [1:0]        out_lane;
    logic              out_last;
    logic              out_ready;

    beat_t             sb[$];
    int                checks = 0;
    int                errors = 0;

    stream_serializer #(.T(logic [31:0]), .LANES(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_mask   (in_mask),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point shared by the sequence and the monitor.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Offer a packet and wait for it to be accepted; expected beats are queued
    // on the cycle the handshake is seen. Returns at rising edge + 1.
    task automatic applyStimulus(input logic [3:0] mask, input logic [3:0][31:0] data,
                                 output int waited);
        bit accepted = 0;
        int top = -1;
        beat_t b;
        in_valid = 1'b1;
        in_mask  = mask;
        in_data  = data;
        waited   = 0;
        for (int c = 0; c < 20 && !accepted; c++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1;
                for (int i = 0; i < 4; i++) if (mask[i]) top = i;
                for (int i = 0; i < 4; i++) begin
                    if (mask[i]) begin
                        b.lane = 2'(i);
                        b.data = data[i];
                        b.last = (i == top);
                        sb.push_back(b);
                    end
                end
            end else begin
                waited++;
            end
            @(posedge clk);
            #1;
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got no accept, expected accept within 20 cycles");
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every transfer pops one expected beat; flush empties the queue.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (flush) begin
                sb.delete();
            end else if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_beat: got lane %0d data %0h, expected no beat",
                             out_lane, out_data);
                end else begin
                    e = sb.pop_front();
                    checkOutput("beat_lane", 64'(out_lane), 64'(e.lane));
                    checkOutput("beat_data", 64'(out_data), 64'(e.data));
                    checkOutput("beat_last", 64'(out_last), 64'(e.last));
                end
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        logic [3:0][31:0] d;
        int w;
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_mask   = '0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset values
        #12;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_last",  64'(out_last),  64'd0);
        checkOutput("rst_out_lane",  64'(out_lane),  64'd0);
        checkOutput("rst_out_data",  64'(out_data),  64'd0);
        checkOutput("rst_in_ready",  64'(in_ready),  64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Sparse mask 1011 streams lanes 0,1,3 back to back
        $display("[TB] mask 1011 with out_ready high");
        out_ready = 1'b1;
        d = {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
        applyStimulus(4'b1011, d, w);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("m1011_b0_lane", 64'(out_lane), 64'd0);
        checkOutput("m1011_b0_last", 64'(out_last), 64'd0);
        @(negedge clk);
        checkOutput("m1011_b1_lane", 64'(out_lane), 64'd1);
        @(negedge clk);
        checkOutput("m1011_b2_lane", 64'(out_lane), 64'd3);
        checkOutput("m1011_b2_data", 64'(out_data), 64'hD3D3_0003);
        checkOutput("m1011_b2_last", 64'(out_last), 64'd1);
        idleCycles(3);

        // Backpressure holds lane 1 steady, then lanes 1 and 2 drain
        $display("[TB] mask 0110 with backpressure");
        out_ready = 1'b0;
        d = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        applyStimulus(4'b0110, d, w);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", 64'(out_valid), 64'd1);
            checkOutput("hold_lane",  64'(out_lane),  64'd1);
            checkOutput("hold_data",  64'(out_data),  64'hB1);
            checkOutput("hold_last",  64'(out_last),  64'd0);
            checkOutput("hold_ready", 64'(in_ready),  64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("drain_lane1", 64'(out_lane), 64'd1);
        @(negedge clk);
        checkOutput("drain_lane2", 64'(out_lane), 64'd2);
        checkOutput("drain_last2", 64'(out_last), 64'd1);
        idleCycles(3);

        // Back-to-back single-lane packets with no bubble
        $display("[TB] back-to-back 0001 then 1000");
        d = {32'h0, 32'h0, 32'h0, 32'hC0C0_0000};
        applyStimulus(4'b0001, d, w);
        d = {32'hC3C3_0003, 32'h0, 32'h0, 32'h0};
        applyStimulus(4'b1000, d, w);
        checkOutput("b2b_no_wait", 64'(w), 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("b2b_valid", 64'(out_valid), 64'd1);
        checkOutput("b2b_lane",  64'(out_lane),  64'd3);
        idleCycles(3);

        // Empty mask is swallowed without output
        $display("[TB] empty mask");
        d = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
        applyStimulus(4'b0000, d, w);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("empty_valid", 64'(out_valid), 64'd0);
        checkOutput("empty_ready", 64'(in_ready),  64'd1);
        idleCycles(2);

        // Flush after the first of four lanes, with a packet on offer
        $display("[TB] flush mid-packet");
        d = {32'hF3, 32'hF2, 32'hF1, 32'hF0};
        applyStimulus(4'b1111, d, w);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        flush    = 1'b1;
        in_valid = 1'b1;
        in_mask  = 4'b1111;
        in_data  = {32'h93, 32'h92, 32'h91, 32'h90};
        @(negedge clk);
        checkOutput("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
        checkOutput("flush_in_ready1", 64'(in_ready),  64'd1);
        idleCycles(3);

        // Asynchronous reset mid-packet
        $display("[TB] async reset mid-packet");
        d = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        applyStimulus(4'b1111, d, w);
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("areset_valid", 64'(out_valid), 64'd0);
        checkOutput("areset_data",  64'(out_data),  64'd0);
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        idleCycles(3);
        @(negedge clk);
        checkOutput("post_reset_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        d = {32'h0, 32'h0, 32'h0, 32'h5555_0000};
        applyStimulus(4'b0001, d, w);
        in_valid = 1'b0;
        idleCycles(4);

        checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_serializer.md
STREAM_SERIALIZER -- requirements
Module: stream_serializer

Interface
REQ-001 SHALL have parameter T, default logic [31:0], the type of one lane payload.
REQ-002 SHALL have parameter LANES, default 4, the lanes per input packet (power of two, >=2).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush  input  1  synchronous discard of all held and offered packet state.
REQ-006 SHALL have port in_valid  input  1  upstream packet offered.
REQ-007 SHALL have port in_mask  input  LANES  per-lane valid bits of the offered packet.
REQ-008 SHALL have port in_data  input  LANES x T  lane payloads; lane 0 is emitted first.
REQ-009 SHALL have port in_ready  output  1  the serializer accepts the offered packet this cycle.
REQ-010 SHALL have port out_valid  output  1  one lane presented downstream.
REQ-011 SHALL have port out_data  output  T  payload of the presented lane.
REQ-012 SHALL have port out_lane  output  $clog2(LANES)  index of the presented lane.
REQ-013 SHALL have port out_last  output  1  presented lane is the final set lane of its packet.
REQ-014 SHALL have port out_ready  input  1  downstream accepts the presented lane.

Function
REQ-015 SHALL hold the packet in registers (data, remaining mask) with states IDLE (remaining == 0) and SEND (remaining != 0).
REQ-016 SHALL define input accept = in_valid && in_ready, and output transfer = out_valid && out_ready.
REQ-017 SHALL drive out_valid = (state == SEND), with no combinational path from any input to out_valid.
REQ-018 SHALL present the lowest-indexed set bit of remaining on out_lane, with out_data the held payload of that lane.
REQ-019 SHALL drive out_last = 1 exactly when remaining has one bit set.
REQ-020 SHALL drive in_ready = !flush && (IDLE || (SEND && out_ready && out_last)), so the next packet loads in the same cycle the last lane transfers (zero-bubble back-to-back).
REQ-021 SHALL, on transfer without accept, clear the presented bit in remaining; on accept, load data and remaining = in_mask.
REQ-022 SHALL accept a packet with in_mask == 0, discard it, and remain IDLE; it produces no output beat.
REQ-023 SHALL keep out_data, out_lane and out_last stable while out_valid && !out_ready.
REQ-024 SHALL emit one lane per cycle while out_ready is held high; a packet with k set lanes takes exactly k transfer cycles, first beat the cycle after accept.
REQ-025 SHALL, when flush is high, clear remaining to 0 at the next edge, drop any packet offered that cycle (in_ready = 0), and ignore out_ready; flush has priority over every other event.
REQ-026 SHALL ignore in_mask and in_data when in_valid is low.

Reset
REQ-027 SHALL, while reset_n is low, asynchronously force remaining = 0 and held data = 0, giving out_valid = 0, out_last = 0, out_lane = 0, out_data = 0, in_ready = 1 (flush low).
REQ-028 SHALL, on reset asserted mid-packet, discard untransferred lanes; the first beat after release is from a newly accepted packet.

Verification
REQ-029 Bench SHALL cover: accept mask 4'b1011, data {D3,D2,D1,D0}, out_ready = 1 -> beats lane0/D0, lane1/D1, lane3/D3 on consecutive cycles, out_last only on lane3.
REQ-030 Bench SHALL cover: mask 4'b0110 with out_ready low for 3 cycles -> lane1/D1 held stable, in_ready = 0, then lane1, lane2 on ready.
REQ-031 Bench SHALL cover: two packets back-to-back (4'b0001 then 4'b1000), in_valid and out_ready held high -> beats lane0 and lane3 in adjacent cycles, no bubble, in_ready high on the last-lane cycle.
REQ-032 Bench SHALL cover: mask 4'b0000 accepted -> no out_valid, in_ready stays 1.
REQ-033 Bench SHALL cover: flush asserted after the first of 4 lanes, with in_valid high -> out_valid 0 next cycle, offered packet dropped, in_ready 1 after flush deasserts.
REQ-034 Bench SHALL cover: reset_n pulled low between clock edges mid-packet -> out_valid falls immediately, no residual beats after release.
